// File: rtl/text_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text overlay renderer:
//   - src_t     : 2-bit ID of the requester that owns the current pixel
//   - COL_*     : 4:4:4 foreground colours per requester, plus the background
//   - src_colour: maps a source ID to its foreground colour
// ----------------------------------------------------------------------------
package text_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_TIME  = 2'd1,
        SRC_SCORE = 2'd2,
        SRC_MSG   = 2'd3
    } src_t;

    localparam logic [11:0] COL_MSG   = 12'hF00;
    localparam logic [11:0] COL_TIME  = 12'hFFF;
    localparam logic [11:0] COL_SCORE = 12'hFF0;
    localparam logic [11:0] COL_BG    = 12'h000;

    localparam int FONT_ADDR_W = 11;
    localparam int FONT_DATA_W = 8;

    function automatic logic [11:0] src_colour(input src_t src);
        logic [11:0] col;
        col = COL_BG;
        case (src)
            SRC_MSG:   col = COL_MSG;
            SRC_TIME:  col = COL_TIME;
            SRC_SCORE: col = COL_SCORE;
            default:   col = COL_BG;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/text_blink.sv
// ----------------------------------------------------------------------------
// text_blink
// Blink timebase for the message overlay. While paused, counts frame ticks
// and toggles blink_phase every BLINK_TICKS ticks. While running, the counter
// is held at 0 and blink_phase at 1 so the message is shown steadily and the
// first blank after a pause begins only after a full half-period.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   refresh_tick in   one-cycle pulse per frame
//   pause        in   game paused (enables blinking)
//   blink_phase  out  1 = message visible, 0 = message blanked
// ----------------------------------------------------------------------------
module text_blink
    import text_pkg::*;
#(
    parameter int BLINK_TICKS = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic refresh_tick,
    input  logic pause,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             phase_reg;
    logic             phase_next;

    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        if (!pause) begin
            // Running dominates a coincident tick: stay parked and visible.
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (refresh_tick) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next   = '0;
                phase_next = ~phase_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

    assign blink_phase = phase_reg;

endmodule

// File: rtl/text_render.sv
// ----------------------------------------------------------------------------
// text_render
// Text overlay pixel pipeline for three text sources (message, time, score)
// sharing one external font ROM.
//   Stage 0 (comb): arbitrate msg > time > score, drive font_addr.
//   Stage 1 (reg) : hold winner ID, glyph column and video_on while the ROM
//                   returns the glyph row on font_data.
//   Stage 2 (reg) : pick the glyph pixel, produce text_on / text_rgb.
// Fixed 2-cycle latency, one pixel per clock, never stalls.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   video_on                           pixel is inside the visible area
//   refresh_tick                       one pulse per frame (blink timebase)
//   pause                              paused; message blinks
//   time_on/score_on/msg_on            requester covers the pixel
//   *_rom_addr [10:0]                  {char[6:0], row[3:0]} font address
//   *_bit_addr [2:0]                   glyph column, 0 = leftmost
//   font_addr [10:0]  out              address to external font ROM
//   font_data [7:0]   in               ROM row, one cycle after font_addr
//   text_on           out              text foreground at this pixel
//   text_rgb [11:0]   out              4:4:4 colour, 0 when text_on = 0
// ----------------------------------------------------------------------------
module text_render
    import text_pkg::*;
#(
    parameter int BLINK_TICKS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        refresh_tick,
    input  logic        pause,
    input  logic        time_on,
    input  logic        score_on,
    input  logic        msg_on,
    input  logic [10:0] time_rom_addr,
    input  logic [10:0] score_rom_addr,
    input  logic [10:0] msg_rom_addr,
    input  logic [2:0]  time_bit_addr,
    input  logic [2:0]  score_bit_addr,
    input  logic [2:0]  msg_bit_addr,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        text_on,
    output logic [11:0] text_rgb
);

    // ------------------------------------------------------------------
    // Blink timebase
    // ------------------------------------------------------------------
    logic blink_phase;

    text_blink #(
        .BLINK_TICKS(BLINK_TICKS)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .refresh_tick(refresh_tick),
        .pause       (pause),
        .blink_phase (blink_phase)
    );

    // ------------------------------------------------------------------
    // Stage 0: arbitration and font address
    // ------------------------------------------------------------------
    logic       msg_req;
    src_t       sel_src;
    logic [2:0] sel_bit;

    // A blanked message drops out of arbitration entirely so time/score
    // text underneath it shows through.
    assign msg_req = msg_on & (~pause | blink_phase);

    always_comb begin
        sel_src   = SRC_NONE;
        sel_bit   = 3'd0;
        font_addr = '0;
        if (msg_req) begin
            sel_src   = SRC_MSG;
            sel_bit   = msg_bit_addr;
            font_addr = msg_rom_addr;
        end else if (time_on) begin
            sel_src   = SRC_TIME;
            sel_bit   = time_bit_addr;
            font_addr = time_rom_addr;
        end else if (score_on) begin
            sel_src   = SRC_SCORE;
            sel_bit   = score_bit_addr;
            font_addr = score_rom_addr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: align pixel context with the ROM read
    // ------------------------------------------------------------------
    src_t       src_d1_reg;
    logic [2:0] bit_d1_reg;
    logic       video_d1_reg;

    // ------------------------------------------------------------------
    // Stage 2: glyph pixel select and colour
    // ------------------------------------------------------------------
    // Reverse the ROM row so column index 0 addresses bit 7 (leftmost).
    logic [FONT_DATA_W-1:0] col_bits;

    generate
        for (genvar gi = 0; gi < FONT_DATA_W; gi++) begin : g_col
            assign col_bits[gi] = font_data[FONT_DATA_W-1-gi];
        end
    endgenerate

    logic        text_on_next;
    logic [11:0] text_rgb_next;
    logic        text_on_reg;
    logic [11:0] text_rgb_reg;

    always_comb begin
        text_on_next  = video_d1_reg & (src_d1_reg != SRC_NONE) & col_bits[bit_d1_reg];
        text_rgb_next = COL_BG;
        if (text_on_next) begin
            text_rgb_next = src_colour(src_d1_reg);
        end
    end

    // Reset clears both stages together so nothing captured before reset
    // can reach the outputs afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_d1_reg   <= SRC_NONE;
            bit_d1_reg   <= 3'd0;
            video_d1_reg <= 1'b0;
            text_on_reg  <= 1'b0;
            text_rgb_reg <= COL_BG;
        end else begin
            src_d1_reg   <= sel_src;
            bit_d1_reg   <= sel_bit;
            video_d1_reg <= video_on;
            text_on_reg  <= text_on_next;
            text_rgb_reg <= text_rgb_next;
        end
    end

    assign text_on  = text_on_reg;
    assign text_rgb = text_rgb_reg;

endmodule

// File: doc/text_render.md
TEXT_RENDER -- requirements
Module: text_render

Interface
REQ-001: Parameter BLINK_TICKS, default 30, meaning refresh_tick count per blink half-period (0.5 s at 60 Hz).
REQ-002: clk  input  1  single system clock; all state on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: video_on  input  1  active display area for the current pixel.
REQ-005: refresh_tick  input  1  one-cycle pulse per frame.
REQ-006: pause  input  1  game paused; enables blinking of the message source.
REQ-007: time_on / score_on / msg_on  input  1 each  requester covers the current pixel.
REQ-008: time_rom_addr / score_rom_addr / msg_rom_addr  input  11 each  {char[6:0], row[3:0]} font address.
REQ-009: time_bit_addr / score_bit_addr / msg_bit_addr  input  3 each  glyph column, 0 = leftmost.
REQ-010: font_addr  output  11  address to external font ROM.
REQ-011: font_data  input  8  font ROM row; valid exactly one cycle after font_addr; bit 7 = leftmost column.
REQ-012: text_on  output  1  text foreground at this pixel.
REQ-013: text_rgb  output  12  4:4:4 colour; 12'h000 when text_on=0.

Function
REQ-014: Stage 0 (combinational) SHALL select one requester by fixed priority msg > time > score and drive font_addr from it; with no requester active, font_addr SHALL be 11'h000.
REQ-015: msg_on SHALL count as a request only when (pause=0) or (blink_phase=1); a blanked msg SHALL let time/score win arbitration.
REQ-016: Stage 1 SHALL register the selected source ID (NONE/TIME/SCORE/MSG), its bit_addr and video_on, aligned with font_data.
REQ-017: Stage 2 SHALL register text_on = video_on_d1 AND source_d1!=NONE AND font_data[7-bit_addr_d1].
REQ-018: Stage 2 SHALL register text_rgb: MSG 12'hF00, TIME 12'hFFF, SCORE 12'hFF0, 12'h000 when text_on would be 0.
REQ-019: Latency from pixel inputs to text_on/text_rgb SHALL be exactly 2 clk cycles, unconditionally, one result per cycle, no stalls.
REQ-020: Blink counter SHALL increment on refresh_tick while pause=1; at BLINK_TICKS-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-021: While pause=0, counter SHALL be held at 0 and blink_phase at 1 (message steady); on pause rise, the first blank SHALL occur after BLINK_TICKS ticks.
REQ-022: refresh_tick coincident with pause deassertion SHALL be ignored (pause=0 dominates).
REQ-023: Counter width SHALL be clog2(BLINK_TICKS), minimum 1 bit.

Reset
REQ-024: On reset=1 at a clock edge: text_on=0, text_rgb=12'h000, stage-1 source=NONE, video_on_d1=0, bit_addr_d1=0, counter=0, blink_phase=1.
REQ-025: Reset mid-frame SHALL flush both pipeline stages; outputs SHALL stay 0 for the reset cycle and the following 1 cycle, valid again on the 2nd cycle after release.

Structure
REQ-026: Shared package text_pkg SHALL hold source-ID encoding (2 bits) and colour constants COL_MSG, COL_TIME, COL_SCORE, COL_BG.
REQ-027: Blink counter/phase SHALL be a sub-module text_blink (clk, reset, refresh_tick, pause -> blink_phase).
REQ-028: Font ROM SHALL remain external; text_render contains no ROM.

Verification
REQ-029: time_on=1, time_rom_addr=11'h540, bit_addr=0, font_data=8'h80 one cycle later, video_on=1 -> text_on=1, text_rgb=12'hFFF two cycles after stimulus.
REQ-030: all three on, msg addr 11'h123, pause=0 -> font_addr=11'h123; font_data=8'h01, msg bit_addr=7 -> text_rgb=12'hF00 at +2.
REQ-031: pause=1, msg_on=1, time_on=1, 30 refresh_ticks -> blink_phase=0, font_addr switches to time_rom_addr, text_rgb=12'hFFF; 30 more ticks -> back to 12'hF00.
REQ-032: video_on=0 with score_on=1, font_data=8'hFF -> text_on=0, text_rgb=12'h000 at +2.
REQ-033: reset pulsed while text_on=1 streaming -> outputs 0 next cycle and cycle after, counter=0, blink_phase=1; pause dropped with refresh_tick same cycle -> counter stays 0.
REQ-034: Random pixel stream vs. reference model -> zero mismatches over 1 full 800x525 frame.
